// File: rtl/signed_divider_sequencer_if.sv
// Request, core-side and response signals of the signed divider sequencer.
// Member names are given from the sequencer's point of view.
`timescale 1ns/1ps
interface signed_divider_sequencer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [DATA_WIDTH-1:0] dividend_i;
  logic [DATA_WIDTH-1:0] divisor_i;
  logic                  signed_i;
  logic [DATA_WIDTH-1:0] div_dividend_o;
  logic [DATA_WIDTH-1:0] div_divisor_o;
  logic                  div_data_valid_o;
  logic [DATA_WIDTH-1:0] div_quotient_i;
  logic [DATA_WIDTH-1:0] div_remainder_i;
  logic                  div_data_valid_i;
  logic                  div_idle_i;
  logic [DATA_WIDTH-1:0] quotient_o;
  logic [DATA_WIDTH-1:0] remainder_o;
  logic                  divide_by_zero_o;
  logic                  overflow_o;
  logic                  resp_valid_o;
  logic                  resp_ready_i;

  modport slave (
    input  req_valid_i, dividend_i, divisor_i, signed_i,
    input  div_quotient_i, div_remainder_i, div_data_valid_i, div_idle_i,
    input  resp_ready_i,
    output req_ready_o, div_dividend_o, div_divisor_o, div_data_valid_o,
    output quotient_o, remainder_o, divide_by_zero_o, overflow_o, resp_valid_o
  );

  modport master (
    output req_valid_i, dividend_i, divisor_i, signed_i,
    output div_quotient_i, div_remainder_i, div_data_valid_i, div_idle_i,
    output resp_ready_i,
    input  req_ready_o, div_dividend_o, div_divisor_o, div_data_valid_o,
    input  quotient_o, remainder_o, divide_by_zero_o, overflow_o, resp_valid_o
  );
endinterface

// File: rtl/signed_divider_sequencer.sv
// Signed/unsigned front/back end for an unsigned divider core: magnitude conversion,
// start pulse, sign fix-up and special cases. Optional macro: DIV_SPECIAL_BYPASS_EN.
`timescale 1ns/1ps
module signed_divider_sequencer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clk_en_i,
  signed_divider_sequencer_if.slave   bus
);
  localparam int MSB = DATA_WIDTH - 1;
  localparam logic [MSB:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESPOND} state_t;

  state_t     state_q, state_d;
  logic       sign_num_q, sign_num_d, sign_den_q, sign_den_d;
  logic       zero_q, zero_d, ovf_flag_q, ovf_flag_d;
  logic [MSB:0] orig_dividend_q, orig_dividend_d;
  logic [MSB:0] div_dividend_q, div_dividend_d, div_divisor_q, div_divisor_d;
  logic       start_q, start_d;
  logic [MSB:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic       dbz_q, dbz_d, ovf_q, ovf_d, resp_valid_q, resp_valid_d;

  logic       accept, req_sign_num, req_sign_den, req_zero, req_ovf;
  logic [MSB:0] fix_quotient, fix_remainder;

  assign bus.req_ready_o = (state_q == ST_IDLE) && bus.div_idle_i && !rst_i;
  assign accept          = bus.req_valid_i && bus.req_ready_o;

  assign req_sign_num = bus.signed_i & bus.dividend_i[MSB];
  assign req_sign_den = bus.signed_i & bus.divisor_i[MSB];
  assign req_zero     = (bus.divisor_i == '0);
  assign req_ovf      = bus.signed_i && (bus.dividend_i == MIN_VAL) && (bus.divisor_i == '1);

  // Negating MIN wraps back to MIN, which the core reads as 2^(W-1).
  assign fix_quotient  = (sign_num_q ^ sign_den_q) ? -bus.div_quotient_i : bus.div_quotient_i;
  assign fix_remainder = sign_num_q ? -bus.div_remainder_i : bus.div_remainder_i;

  always_comb begin
    state_d         = state_q;
    sign_num_d      = sign_num_q;
    sign_den_d      = sign_den_q;
    zero_d          = zero_q;
    ovf_flag_d      = ovf_flag_q;
    orig_dividend_d = orig_dividend_q;
    div_dividend_d  = div_dividend_q;
    div_divisor_d   = div_divisor_q;
    start_d         = 1'b0;
    quotient_d      = quotient_q;
    remainder_d     = remainder_q;
    dbz_d           = dbz_q;
    ovf_d           = ovf_q;
    resp_valid_d    = resp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sign_num_d      = req_sign_num;
          sign_den_d      = req_sign_den;
          div_dividend_d  = req_sign_num ? -bus.dividend_i : bus.dividend_i;
          div_divisor_d   = req_sign_den ? -bus.divisor_i : bus.divisor_i;
          orig_dividend_d = bus.dividend_i;
          zero_d          = req_zero;
          ovf_flag_d      = req_ovf;
`ifdef DIV_SPECIAL_BYPASS_EN
          if (req_zero || req_ovf) begin
            state_d      = ST_RESPOND;
            resp_valid_d = 1'b1;
            quotient_d   = req_zero ? '1 : MIN_VAL;
            remainder_d  = req_zero ? bus.dividend_i : '0;
            dbz_d        = req_zero;
            ovf_d        = req_ovf;
          end else begin
            state_d = ST_ISSUE;
            start_d = 1'b1;
          end
`else
          state_d = ST_ISSUE;
          start_d = 1'b1;
`endif
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.div_data_valid_i) begin
          quotient_d   = zero_q ? '1 : fix_quotient;
          remainder_d  = zero_q ? orig_dividend_q : fix_remainder;
          dbz_d        = zero_q;
          ovf_d        = ovf_flag_q;
          resp_valid_d = 1'b1;
          state_d      = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (bus.resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      sign_num_q      <= 1'b0;
      sign_den_q      <= 1'b0;
      zero_q          <= 1'b0;
      ovf_flag_q      <= 1'b0;
      orig_dividend_q <= '0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      start_q         <= 1'b0;
      quotient_q      <= '0;
      remainder_q     <= '0;
      dbz_q           <= 1'b0;
      ovf_q           <= 1'b0;
      resp_valid_q    <= 1'b0;
    end else if (clk_en_i) begin
      state_q         <= state_d;
      sign_num_q      <= sign_num_d;
      sign_den_q      <= sign_den_d;
      zero_q          <= zero_d;
      ovf_flag_q      <= ovf_flag_d;
      orig_dividend_q <= orig_dividend_d;
      div_dividend_q  <= div_dividend_d;
      div_divisor_q   <= div_divisor_d;
      start_q         <= start_d;
      quotient_q      <= quotient_d;
      remainder_q     <= remainder_d;
      dbz_q           <= dbz_d;
      ovf_q           <= ovf_d;
      resp_valid_q    <= resp_valid_d;
    end
  end

  assign bus.div_dividend_o   = div_dividend_q;
  assign bus.div_divisor_o    = div_divisor_q;
  assign bus.div_data_valid_o = start_q;
  assign bus.quotient_o       = quotient_q;
  assign bus.remainder_o      = remainder_q;
  assign bus.divide_by_zero_o = dbz_q;
  assign bus.overflow_o       = ovf_q;
  assign bus.resp_valid_o     = resp_valid_q;
endmodule

// File: tb/tb_signed_divider_sequencer.sv
// Bench for signed_divider_sequencer: behavioural divider core, arithmetic reference
// model with a response scoreboard, directed corner cases and randomized traffic.
`timescale 1ns/1ps
module tb_signed_divider_sequencer;
  localparam int W = 16;
  localparam logic [W-1:0] MIN_V = 16'h8000;
`ifdef DIV_SPECIAL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic clk_en;

  signed_divider_sequencer_if #(.DATA_WIDTH(W)) bus();

  signed_divider_sequencer #(.DATA_WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clk_en_i (clk_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } resp_t;

  resp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int exp_starts = 0;
  int seen_starts = 0;
  bit en_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, plus special cases.
  function automatic resp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    resp_t res;
    int sa, sb;
    res = '0;
    if (b == '0) begin
      res.q = '1; res.r = a; res.dbz = 1'b1;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -32768 && sb == -1) begin
        res.q = MIN_V; res.r = '0; res.ovf = 1'b1;
      end else begin
        res.q = W'(sa / sb);
        res.r = W'(sa % sb);
      end
    end else begin
      res.q = a / b;
      res.r = a % b;
    end
    return res;
  endfunction

  // Behavioural divider core: samples the start pulse, answers after a latency.
  bit core_busy = 1'b0;
  int core_cnt = 0;
  int idle_cnt = 0;
  int force_lat = 0;
  bit inject_stray = 1'b0;
  bit start_prev = 1'b0;
  logic [W-1:0] core_a, core_b;

  initial begin
    bus.div_idle_i = 1'b0;
    bus.div_data_valid_i = 1'b0;
    bus.div_quotient_i = '0;
    bus.div_remainder_i = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        core_busy = 1'b0;
        bus.div_data_valid_i = 1'b0;
        bus.div_idle_i = 1'b0;
        idle_cnt = 3;
      end else if (clk_en) begin
        if (bus.div_data_valid_i) bus.div_data_valid_i = 1'b0;
        if (idle_cnt > 0) begin
          idle_cnt--;
          if (idle_cnt == 0) bus.div_idle_i = 1'b1;
        end else if (core_busy) begin
          core_cnt--;
          if (core_cnt == 0) begin
            core_busy = 1'b0;
            bus.div_idle_i = 1'b1;
            bus.div_data_valid_i = 1'b1;
            bus.div_quotient_i = (core_b == '0) ? '1 : core_a / core_b;
            bus.div_remainder_i = (core_b == '0) ? core_a : core_a % core_b;
          end
        end else if (start_prev) begin
          core_a = bus.div_dividend_o;
          core_b = bus.div_divisor_o;
          core_busy = 1'b1;
          bus.div_idle_i = 1'b0;
          core_cnt = (force_lat != 0) ? force_lat : int'($urandom_range(1, 5));
        end
        if (inject_stray) begin
          bus.div_data_valid_i = 1'b1;
          bus.div_quotient_i = 16'h1234;
          bus.div_remainder_i = 16'h5678;
          inject_stray = 1'b0;
        end
      end
      start_prev = bus.div_data_valid_o;
    end
  end

  // Compare process: every cycle a response is presented it must match the scoreboard head.
  initial begin
    bit prev_valid, prev_dv;
    prev_valid = 1'b0;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.div_data_valid_o) begin
        if (!prev_dv) seen_starts++;
        else check("start_pulse_width", 32'(prev_dv & clk_en), 32'd0);
      end
      if (bus.resp_valid_o) begin
        check("resp_blocks_req", 32'(bus.req_ready_o), 32'd0);
        if (exp_q.size() == 0) begin
          check("spurious_resp", 32'(bus.resp_valid_o), 32'd0);
        end else begin
          check("resp_quotient", 32'(bus.quotient_o), 32'(exp_q[0].q));
          check("resp_remainder", 32'(bus.remainder_o), 32'(exp_q[0].r));
          check("resp_dbz", 32'(bus.divide_by_zero_o), 32'(exp_q[0].dbz));
          check("resp_overflow", 32'(bus.overflow_o), 32'(exp_q[0].ovf));
        end
      end else if (prev_valid && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
      prev_valid = bus.resp_valid_o;
      prev_dv = bus.div_data_valid_o;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #2;
    clk_en = en_rand ? ($urandom_range(0, 99) < 85) : 1'b1;
  endtask

  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output bit ok);
    int n;
    bit special;
    n = 0;
    ok = 1'b0;
    special = (b == '0) || (s && a == MIN_V && b == '1);
    bus.req_valid_i = 1'b1;
    bus.dividend_i = a;
    bus.divisor_i = b;
    bus.signed_i = s;
    while (n < 300) begin
      #1;
      if (bus.req_ready_o && clk_en && !rst) begin
        ok = 1'b1;
        exp_q.push_back(ref_div(a, b, s));
        if (!(BYPASS && special)) exp_starts++;
        break;
      end
      n++;
      #1;
      step();
    end
    check("req_accept_timeout", 32'(ok), 32'd1);
    step();
    bus.req_valid_i = 1'b0;
    bus.dividend_i = W'($urandom);
    bus.divisor_i = W'($urandom);
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!bus.resp_valid_o && n < 100) begin
      step();
      n++;
    end
    ok = bus.resp_valid_o;
    check("resp_valid_timeout", 32'(ok), 32'd1);
  endtask

  task automatic finish_resp(input int ready_pct, output bit ok);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    ok = 1'b0;
    while (n < 400) begin
      if (bus.resp_valid_o) begin
        seen = 1'b1;
        bus.resp_ready_i = ($urandom_range(0, 99) < ready_pct);
      end else begin
        bus.resp_ready_i = 1'b0;
        if (seen) begin
          ok = 1'b1;
          break;
        end
      end
      step();
      n++;
    end
    bus.resp_ready_i = 1'b0;
    check("resp_handshake_timeout", 32'(ok), 32'd1);
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input logic eovf);
    bit ok, special;
    special = (b == '0) || (s && a == MIN_V && b == '1);
    do_req(a, b, s, ok);
    check("latency_resp_valid", 32'(bus.resp_valid_o), 32'(BYPASS && special));
    check("latency_start", 32'(bus.div_data_valid_o), 32'(!(BYPASS && special)));
    wait_valid(ok);
    check("lit_quotient", 32'(bus.quotient_o), 32'(eq));
    check("lit_remainder", 32'(bus.remainder_o), 32'(er));
    check("lit_dbz", 32'(bus.divide_by_zero_o), 32'(edbz));
    check("lit_overflow", 32'(bus.overflow_o), 32'(eovf));
    finish_resp(100, ok);
  endtask

  initial begin
    bit ok;
    int n;
    logic [W-1:0] a, b;
    logic s;
    rst = 1'b1;
    clk_en = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i = '0;
    bus.signed_i = 1'b0;
    bus.resp_ready_i = 1'b0;
    repeat (3) step();
    check("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    check("rst_start", 32'(bus.div_data_valid_o), 32'd0);
    check("rst_quotient", 32'(bus.quotient_o), 32'd0);
    check("rst_remainder", 32'(bus.remainder_o), 32'd0);
    check("rst_dbz", 32'(bus.divide_by_zero_o), 32'd0);
    check("rst_overflow", 32'(bus.overflow_o), 32'd0);
    check("rst_div_dividend", 32'(bus.div_dividend_o), 32'd0);
    check("rst_div_divisor", 32'(bus.div_divisor_o), 32'd0);
    rst = 1'b0;
    step();

    directed(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    directed(16'hFFF9, 16'h0002, 1'b0, 16'h7FFC, 16'h0001, 1'b0, 1'b0);
    directed(16'd100, 16'h0000, 1'b1, 16'hFFFF, 16'h0064, 1'b1, 1'b0);
    directed(16'd100, 16'h0000, 1'b0, 16'hFFFF, 16'h0064, 1'b1, 1'b0);
    directed(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1);
    directed(16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0);
    directed(16'hFF9C, 16'hFFF9, 1'b1, 16'h000E, 16'hFFFE, 1'b0, 1'b0);
    directed(16'h8000, 16'h0003, 1'b1, 16'hD556, 16'hFFFE, 1'b0, 1'b0);

    // Response held off for five cycles while another request waits.
    do_req(16'd1000, 16'd7, 1'b0, ok);
    wait_valid(ok);
    bus.req_valid_i = 1'b1;
    bus.dividend_i = 16'd5;
    bus.divisor_i = 16'd1;
    bus.signed_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.resp_ready_i = 1'b0;
      step();
      check("hold_req_ready", 32'(bus.req_ready_o), 32'd0);
      check("hold_resp_valid", 32'(bus.resp_valid_o), 32'd1);
      check("hold_quotient", 32'(bus.quotient_o), 32'h008E);
      check("hold_remainder", 32'(bus.remainder_o), 32'h0006);
    end
    bus.req_valid_i = 1'b0;
    bus.resp_ready_i = 1'b1;
    step();
    bus.resp_ready_i = 1'b0;
    check("release_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    check("release_req_ready", 32'(bus.req_ready_o), 32'd1);

    // Reset while the core is computing; the late and stray result pulses must vanish.
    force_lat = 12;
    do_req(16'd1000, 16'd3, 1'b1, ok);
    n = 0;
    while (!core_busy && n < 50) begin
      step();
      n++;
    end
    step();
    step();
    check("pre_reset_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    rst = 1'b1;
    step();
    check("reset_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    check("reset_start", 32'(bus.div_data_valid_o), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready_o), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    force_lat = 0;
    step();
    check("ready_waits_core_idle", 32'(bus.req_ready_o), 32'd0);
    n = 0;
    while (!bus.req_ready_o && n < 20) begin
      step();
      n++;
    end
    check("ready_after_reset", 32'(bus.req_ready_o), 32'd1);
    inject_stray = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("stray_no_resp", 32'(bus.resp_valid_o), 32'd0);
    end
    directed(16'd1000, 16'd3, 1'b1, 16'd333, 16'd1, 1'b0, 1'b0);

    // Randomized traffic with clock-enable gaps and response back-pressure.
    en_rand = 1'b1;
    for (int t = 0; t < 150; t++) begin
      s = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = MIN_V; b = '1; s = 1'b1; end
        2: a = MIN_V;
        3: b = W'($urandom_range(1, 9));
        default: ;
      endcase
      do_req(a, b, s, ok);
      finish_resp(60, ok);
    end
    en_rand = 1'b0;
    repeat (3) step();
    check("start_pulse_count", 32'(seen_starts), 32'(exp_starts));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
